// File: rtl/ctrl_pipe_regs_if.sv
// ctrl_pipe_regs_if: bundle between the ID-stage control source and the
// control pipeline registers.
//   master : drives hold/flush and the decoded ID instruction, observes the
//            per-stage control words, stall and the event counters.
//   slave  : the pipeline register block itself.
interface ctrl_pipe_regs_if #(
    parameter int unsigned CNT_W = 16
);
    // Global controls from the core
    logic             hold;
    logic             flush;

    // Decoded instruction sitting in ID
    logic             id_valid;
    logic [7:0]       id_ctrl;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs2;
    logic [4:0]       id_rd;

    // Hazard indication back to PC / IF-ID
    logic             stall;

    // EX stage
    logic             ex_valid;
    logic [7:0]       ex_ctrl;
    logic [4:0]       ex_rd;

    // MEM stage
    logic             mem_valid;
    logic [7:0]       mem_ctrl;
    logic [4:0]       mem_rd;

    // WB stage
    logic             wb_valid;
    logic             wb_regwrite;
    logic             wb_memtoreg;
    logic [4:0]       wb_rd;

    // Event counters
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output hold, flush,
        output id_valid, id_ctrl, id_rs1, id_rs2, id_uses_rs2, id_rd,
        input  stall,
        input  ex_valid, ex_ctrl, ex_rd,
        input  mem_valid, mem_ctrl, mem_rd,
        input  wb_valid, wb_regwrite, wb_memtoreg, wb_rd,
        input  stall_count, flush_count
    );

    modport slave (
        input  hold, flush,
        input  id_valid, id_ctrl, id_rs1, id_rs2, id_uses_rs2, id_rd,
        output stall,
        output ex_valid, ex_ctrl, ex_rd,
        output mem_valid, mem_ctrl, mem_rd,
        output wb_valid, wb_regwrite, wb_memtoreg, wb_rd,
        output stall_count, flush_count
    );
endinterface

// File: rtl/ctrl_pipe_regs.sv
// ctrl_pipe_regs: ID/EX, EX/MEM and MEM/WB control pipeline registers of the
// 5-stage RISC-V core. Captures the decoded control word from ID, detects
// load-use hazards (inserting a bubble), applies flush and global hold, and
// keeps saturating stall/flush event counters.
// Ports:
//   clk   : core clock, rising edge
//   reset : asynchronous, active-high; clears every stage and counter
//   bus   : ctrl_pipe_regs_if.slave (ID inputs, hold/flush, stage outputs,
//           combinational stall, counters)
module ctrl_pipe_regs #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    ctrl_pipe_regs_if.slave  bus
);

    localparam int unsigned REG_W = 5;

    // Control word packing: {branch, memread, memwrite, memtoreg, regwrite, alusrc, aluop[1:0]}
    typedef struct packed {
        logic       branch;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrc;
        logic [1:0] aluop;
    } ctrl_t;

    typedef struct packed {
        logic             valid;
        ctrl_t            ctrl;
        logic [REG_W-1:0] rd;
    } stage_t;

    localparam stage_t           BUBBLE  = '0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    stage_t           ex_q,  ex_d;
    stage_t           mem_q, mem_d;
    logic             wb_valid_q,    wb_valid_d;
    logic             wb_regwrite_q, wb_regwrite_d;
    logic             wb_memtoreg_q, wb_memtoreg_d;
    logic [REG_W-1:0] wb_rd_q,       wb_rd_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    logic             stall_c;
    logic             advance_c;
    stage_t           capture_c;

    // Load-use hazard: the load now in EX writes a register the ID instruction reads.
    // A pending flush kills the ID instruction, so it cannot be a hazard victim.
    always_comb begin
        logic ex_rd_nz;
        logic rs1_hit;
        logic rs2_hit;
        ex_rd_nz = (ex_q.rd != '0);
        rs1_hit  = (ex_q.rd == bus.id_rs1);
        rs2_hit  = bus.id_uses_rs2 & (ex_q.rd == bus.id_rs2);
        stall_c  = ~reset & bus.id_valid & ex_q.valid & ex_q.ctrl.memread
                 & ex_rd_nz & (rs1_hit | rs2_hit) & ~bus.flush;
    end

    // Pipeline advances on every edge that is not frozen by hold
    always_comb begin
        advance_c = ~bus.hold;
    end

    // Value ID/EX would load this edge: bubble on flush, stall or empty ID
    always_comb begin
        capture_c = BUBBLE;
        if (bus.id_valid && !bus.flush && !stall_c) begin
            capture_c.valid = 1'b1;
            capture_c.ctrl  = ctrl_t'(bus.id_ctrl);
            capture_c.rd    = bus.id_rd;
            // Writes to x0 are architecturally discarded; drop the enable here
            if (bus.id_rd == '0) begin
                capture_c.ctrl.regwrite = 1'b0;
            end
        end
    end

    // Stage register next-state
    always_comb begin
        ex_d          = ex_q;
        mem_d         = mem_q;
        wb_valid_d    = wb_valid_q;
        wb_regwrite_d = wb_regwrite_q;
        wb_memtoreg_d = wb_memtoreg_q;
        wb_rd_d       = wb_rd_q;
        if (advance_c) begin
            ex_d          = capture_c;
            mem_d         = ex_q;
            wb_valid_d    = mem_q.valid;
            wb_regwrite_d = mem_q.valid & mem_q.ctrl.regwrite;
            wb_memtoreg_d = mem_q.ctrl.memtoreg;
            wb_rd_d       = mem_q.rd;
        end
    end

    // Saturating event counters; frozen while hold is asserted
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (advance_c && stall_c && (stall_count_q != CNT_MAX)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
        if (advance_c && bus.flush && (flush_count_q != CNT_MAX)) begin
            flush_count_d = flush_count_q + CNT_W'(1);
        end
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q          <= BUBBLE;
            mem_q         <= BUBBLE;
            wb_valid_q    <= 1'b0;
            wb_regwrite_q <= 1'b0;
            wb_memtoreg_q <= 1'b0;
            wb_rd_q       <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            ex_q          <= ex_d;
            mem_q         <= mem_d;
            wb_valid_q    <= wb_valid_d;
            wb_regwrite_q <= wb_regwrite_d;
            wb_memtoreg_q <= wb_memtoreg_d;
            wb_rd_q       <= wb_rd_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    // Output mapping
    assign bus.stall       = stall_c;
    assign bus.ex_valid    = ex_q.valid;
    assign bus.ex_ctrl     = ex_q.ctrl;
    assign bus.ex_rd       = ex_q.rd;
    assign bus.mem_valid   = mem_q.valid;
    assign bus.mem_ctrl    = mem_q.ctrl;
    assign bus.mem_rd      = mem_q.rd;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_regwrite = wb_regwrite_q;
    assign bus.wb_memtoreg = wb_memtoreg_q;
    assign bus.wb_rd       = wb_rd_q;
    assign bus.stall_count = stall_count_q;
    assign bus.flush_count = flush_count_q;

endmodule

// File: tb/tb_ctrl_pipe_regs.sv
// tb_ctrl_pipe_regs: directed scenarios plus randomized traffic for
// ctrl_pipe_regs, checked against an in-bench pipeline model. A second
// instance with 2-bit counters shares the stimulus to exercise saturation.
module tb_ctrl_pipe_regs;

    logic clk;
    logic reset;

    ctrl_pipe_regs_if #(.CNT_W(16)) bus ();
    ctrl_pipe_regs_if #(.CNT_W(2))  bus_s ();

    ctrl_pipe_regs #(.CNT_W(16)) dut   (.clk(clk), .reset(reset), .bus(bus));
    ctrl_pipe_regs #(.CNT_W(2))  dut_s (.clk(clk), .reset(reset), .bus(bus_s));

    assign bus_s.hold        = bus.hold;
    assign bus_s.flush       = bus.flush;
    assign bus_s.id_valid    = bus.id_valid;
    assign bus_s.id_ctrl     = bus.id_ctrl;
    assign bus_s.id_rs1      = bus.id_rs1;
    assign bus_s.id_rs2      = bus.id_rs2;
    assign bus_s.id_uses_rs2 = bus.id_uses_rs2;
    assign bus_s.id_rd       = bus.id_rd;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt;
    int total_cnt;

    // Model: index 0 = EX, 1 = MEM, 2 = WB
    logic       m_v [3];
    logic [7:0] m_c [3];
    logic [4:0] m_r [3];
    int         m_sc, m_fc, m_sc2, m_fc2;

    localparam logic [7:0] R_CTRL  = 8'b0000_1010;
    localparam logic [7:0] LD_CTRL = 8'b0101_1100;

    function automatic int sat_inc(input int v, input int max);
        return (v < max) ? v + 1 : v;
    endfunction

    function automatic logic model_stall();
        logic hit;
        hit = (m_r[0] == bus.id_rs1) || (bus.id_uses_rs2 && (m_r[0] == bus.id_rs2));
        return bus.id_valid && m_v[0] && m_c[0][6] && (m_r[0] != 5'd0) && hit && !bus.flush;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            m_v[i] = 1'b0; m_c[i] = 8'h00; m_r[i] = 5'd0;
        end
        m_sc = 0; m_fc = 0; m_sc2 = 0; m_fc2 = 0;
    endtask

    task automatic drive(input logic v, input logic [7:0] c, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd);
        bus.id_valid = v; bus.id_ctrl = c; bus.id_rs1 = rs1;
        bus.id_rs2 = rs2; bus.id_uses_rs2 = u2; bus.id_rd = rd;
    endtask

    // Advance one clock, updating the model from the current inputs first
    task automatic step();
        logic st;
        st = model_stall();
        if (!bus.hold) begin
            for (int i = 2; i > 0; i--) begin
                m_v[i] = m_v[i-1]; m_c[i] = m_c[i-1]; m_r[i] = m_r[i-1];
            end
            if (bus.flush || st || !bus.id_valid) begin
                m_v[0] = 1'b0; m_c[0] = 8'h00; m_r[0] = 5'd0;
            end else begin
                m_v[0] = 1'b1;
                m_c[0] = (bus.id_rd == 5'd0) ? (bus.id_ctrl & 8'hF7) : bus.id_ctrl;
                m_r[0] = bus.id_rd;
            end
            if (st) begin m_sc = sat_inc(m_sc, 65535); m_sc2 = sat_inc(m_sc2, 3); end
            if (bus.flush) begin m_fc = sat_inc(m_fc, 65535); m_fc2 = sat_inc(m_fc2, 3); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.hold = 1'b0; bus.flush = 1'b0;
        drive(1'b0, 8'h00, 5'd0, 5'd0, 1'b0, 5'd0);
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.hold = 1'b0; bus.flush = 1'b0;
        drive(1'b1, LD_CTRL, 5'd3, 5'd3, 1'b1, 5'd3);
        model_clear();
        @(posedge clk); #1;
        @(posedge clk); #1;
        total_cnt++;
        if ({bus.ex_valid, bus.mem_valid, bus.wb_valid, bus.wb_regwrite, bus.stall} !== 5'b0)
            $display("FAIL reset_valids got %b exp 00000",
                     {bus.ex_valid, bus.mem_valid, bus.wb_valid, bus.wb_regwrite, bus.stall});
        else pass_cnt++;
        total_cnt++;
        if ({bus.ex_ctrl, bus.ex_rd, bus.mem_ctrl, bus.mem_rd, bus.wb_rd, bus.stall_count, bus.flush_count} !== '0)
            $display("FAIL reset_fields got ex_ctrl=%h mem_ctrl=%h wb_rd=%0d sc=%0d fc=%0d exp all 0",
                     bus.ex_ctrl, bus.mem_ctrl, bus.wb_rd, bus.stall_count, bus.flush_count);
        else pass_cnt++;
        reset = 1'b0;
    endtask

    task automatic test_passthrough();
        do_reset();
        drive(1'b1, R_CTRL, 5'd1, 5'd2, 1'b1, 5'd5);
        step();
        total_cnt++;
        if ({bus.ex_valid, bus.ex_ctrl, bus.ex_rd} !== {1'b1, 8'h0A, 5'd5})
            $display("FAIL pass_ex got v=%b ctrl=%h rd=%0d exp v=1 ctrl=0a rd=5", bus.ex_valid, bus.ex_ctrl, bus.ex_rd);
        else pass_cnt++;
        drive(1'b0, 8'h00, 5'd0, 5'd0, 1'b0, 5'd0);
        step();
        total_cnt++;
        if ({bus.mem_valid, bus.mem_ctrl, bus.mem_rd, bus.ex_valid} !== {1'b1, 8'h0A, 5'd5, 1'b0})
            $display("FAIL pass_mem got v=%b ctrl=%h rd=%0d exv=%b exp v=1 ctrl=0a rd=5 exv=0",
                     bus.mem_valid, bus.mem_ctrl, bus.mem_rd, bus.ex_valid);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({bus.wb_valid, bus.wb_regwrite, bus.wb_memtoreg, bus.wb_rd} !== {1'b1, 1'b1, 1'b0, 5'd5})
            $display("FAIL pass_wb got v=%b rw=%b m2r=%b rd=%0d exp v=1 rw=1 m2r=0 rd=5",
                     bus.wb_valid, bus.wb_regwrite, bus.wb_memtoreg, bus.wb_rd);
        else pass_cnt++;
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1'b1, LD_CTRL, 5'd1, 5'd0, 1'b0, 5'd7);
        step();
        drive(1'b1, R_CTRL, 5'd7, 5'd2, 1'b1, 5'd8);
        #1;
        total_cnt++;
        if (bus.stall !== 1'b1) $display("FAIL lu_stall got %b exp 1", bus.stall);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({bus.ex_valid, bus.ex_ctrl, bus.stall_count, bus.stall} !== {1'b0, 8'h00, 16'd1, 1'b0})
            $display("FAIL lu_bubble got exv=%b ctrl=%h sc=%0d stall=%b exp 0 00 1 0",
                     bus.ex_valid, bus.ex_ctrl, bus.stall_count, bus.stall);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({bus.ex_valid, bus.ex_ctrl, bus.ex_rd, bus.stall_count} !== {1'b1, 8'h0A, 5'd8, 16'd1})
            $display("FAIL lu_capture got v=%b ctrl=%h rd=%0d sc=%0d exp 1 0a 8 1",
                     bus.ex_valid, bus.ex_ctrl, bus.ex_rd, bus.stall_count);
        else pass_cnt++;
        total_cnt++;
        if ({bus.mem_valid, bus.mem_ctrl, bus.mem_rd} !== {1'b0, 8'h00, 5'd0})
            $display("FAIL lu_mem_bubble got v=%b ctrl=%h rd=%0d exp 0 00 0", bus.mem_valid, bus.mem_ctrl, bus.mem_rd);
        else pass_cnt++;
    endtask

    task automatic test_no_false_hazard();
        do_reset();
        drive(1'b1, LD_CTRL, 5'd1, 5'd0, 1'b0, 5'd0);
        step();
        total_cnt++;
        if (bus.ex_ctrl !== 8'h54) $display("FAIL x0_regwrite got %h exp 54", bus.ex_ctrl);
        else pass_cnt++;
        drive(1'b1, R_CTRL, 5'd0, 5'd0, 1'b1, 5'd4);
        #1;
        total_cnt++;
        if (bus.stall !== 1'b0) $display("FAIL nfh_x0 got %b exp 0", bus.stall);
        else pass_cnt++;
        step();
        drive(1'b1, LD_CTRL, 5'd1, 5'd0, 1'b0, 5'd7);
        step();
        drive(1'b1, R_CTRL, 5'd3, 5'd7, 1'b0, 5'd4);
        #1;
        total_cnt++;
        if (bus.stall !== 1'b0) $display("FAIL nfh_rs2_unused got %b exp 0", bus.stall);
        else pass_cnt++;
        bus.id_uses_rs2 = 1'b1;
        #1;
        total_cnt++;
        if (bus.stall !== 1'b1) $display("FAIL hz_rs2_used got %b exp 1", bus.stall);
        else pass_cnt++;
        drive(1'b0, 8'h00, 5'd0, 5'd0, 1'b0, 5'd0);
        step();
    endtask

    task automatic test_flush_hazard();
        do_reset();
        drive(1'b1, LD_CTRL, 5'd1, 5'd0, 1'b0, 5'd7);
        step();
        drive(1'b1, R_CTRL, 5'd7, 5'd2, 1'b1, 5'd8);
        bus.flush = 1'b1;
        #1;
        total_cnt++;
        if (bus.stall !== 1'b0) $display("FAIL fh_stall got %b exp 0", bus.stall);
        else pass_cnt++;
        step();
        bus.flush = 1'b0;
        total_cnt++;
        if ({bus.ex_valid, bus.ex_ctrl, bus.flush_count, bus.stall_count} !== {1'b0, 8'h00, 16'd1, 16'd0})
            $display("FAIL fh_result got v=%b ctrl=%h fc=%0d sc=%0d exp 0 00 1 0",
                     bus.ex_valid, bus.ex_ctrl, bus.flush_count, bus.stall_count);
        else pass_cnt++;
    endtask

    task automatic test_hold();
        do_reset();
        drive(1'b1, R_CTRL, 5'd1, 5'd2, 1'b1, 5'd5);
        step();
        drive(1'b1, LD_CTRL, 5'd1, 5'd0, 1'b0, 5'd9);
        step();
        bus.hold = 1'b1;
        bus.flush = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 8'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 5'($urandom));
            step();
            total_cnt++;
            if ({bus.ex_valid, bus.ex_ctrl, bus.ex_rd, bus.mem_ctrl, bus.mem_rd, bus.wb_valid,
                 bus.flush_count, bus.stall_count} !==
                {1'b1, 8'h5C, 5'd9, 8'h0A, 5'd5, 1'b0, 16'd0, 16'd0})
                $display("FAIL hold_frozen_%0d got ex=%h/%0d mem=%h/%0d wbv=%b fc=%0d sc=%0d",
                         k, bus.ex_ctrl, bus.ex_rd, bus.mem_ctrl, bus.mem_rd, bus.wb_valid,
                         bus.flush_count, bus.stall_count);
            else pass_cnt++;
        end
        bus.hold = 1'b0;
        step();
        bus.flush = 1'b0;
        total_cnt++;
        if ({bus.flush_count, bus.ex_valid, bus.mem_ctrl, bus.wb_regwrite, bus.wb_rd} !==
            {16'd1, 1'b0, 8'h5C, 1'b1, 5'd5})
            $display("FAIL hold_release got fc=%0d exv=%b mem=%h wbrw=%b wbrd=%0d exp 1 0 5c 1 5",
                     bus.flush_count, bus.ex_valid, bus.mem_ctrl, bus.wb_regwrite, bus.wb_rd);
        else pass_cnt++;
        drive(1'b0, 8'h00, 5'd0, 5'd0, 1'b0, 5'd0);
        step();
        total_cnt++;
        if (bus.flush_count !== 16'd1) $display("FAIL hold_once got fc=%0d exp 1", bus.flush_count);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.flush = 1'b1;
        drive(1'b1, R_CTRL, 5'd1, 5'd2, 1'b1, 5'd3);
        step();
        bus.flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, R_CTRL, 5'd1, 5'd2, 1'b1, 5'(10 + k));
            step();
        end
        #2;
        reset = 1'b1;
        #1;
        total_cnt++;
        if ({bus.ex_valid, bus.mem_valid, bus.wb_valid, bus.wb_regwrite, bus.wb_memtoreg, bus.stall} !== 6'b0)
            $display("FAIL areset_valids got %b exp 000000",
                     {bus.ex_valid, bus.mem_valid, bus.wb_valid, bus.wb_regwrite, bus.wb_memtoreg, bus.stall});
        else pass_cnt++;
        total_cnt++;
        if ({bus.ex_ctrl, bus.ex_rd, bus.mem_ctrl, bus.mem_rd, bus.wb_rd, bus.flush_count, bus.stall_count} !== '0)
            $display("FAIL areset_fields got ex=%h mem=%h wbrd=%0d fc=%0d exp 0",
                     bus.ex_ctrl, bus.mem_ctrl, bus.wb_rd, bus.flush_count);
        else pass_cnt++;
        model_clear();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, LD_CTRL, 5'd1, 5'd0, 1'b0, 5'd7);
            step();
            drive(1'b1, R_CTRL, 5'd7, 5'd2, 1'b1, 5'd8);
            step();
        end
        total_cnt++;
        if ({bus.stall_count, bus_s.stall_count} !== {16'd5, 2'd3})
            $display("FAIL sat_stall got wide=%0d narrow=%0d exp 5 3", bus.stall_count, bus_s.stall_count);
        else pass_cnt++;
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            bus.hold  = ($urandom_range(0, 9) == 0);
            bus.flush = ($urandom_range(0, 7) == 0);
            drive(1'($urandom_range(0, 4) != 0),
                  ($urandom_range(0, 1) == 1) ? LD_CTRL : 8'($urandom),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom), 5'($urandom_range(0, 3)));
            #1;
            total_cnt++;
            if (bus.stall !== model_stall()) $display("FAIL rnd_stall_%0d got %b exp %b", n, bus.stall, model_stall());
            else pass_cnt++;
            step();
            total_cnt++;
            if ({bus.ex_valid, bus.ex_ctrl, bus.ex_rd} !== {m_v[0], m_c[0], m_r[0]})
                $display("FAIL rnd_ex_%0d got %b/%h/%0d exp %b/%h/%0d", n,
                         bus.ex_valid, bus.ex_ctrl, bus.ex_rd, m_v[0], m_c[0], m_r[0]);
            else pass_cnt++;
            total_cnt++;
            if ({bus.mem_valid, bus.mem_ctrl, bus.mem_rd} !== {m_v[1], m_c[1], m_r[1]})
                $display("FAIL rnd_mem_%0d got %b/%h/%0d exp %b/%h/%0d", n,
                         bus.mem_valid, bus.mem_ctrl, bus.mem_rd, m_v[1], m_c[1], m_r[1]);
            else pass_cnt++;
            total_cnt++;
            if ({bus.wb_valid, bus.wb_regwrite, bus.wb_memtoreg, bus.wb_rd} !==
                {m_v[2], m_v[2] & m_c[2][3], m_c[2][4], m_r[2]})
                $display("FAIL rnd_wb_%0d got %b%b%b/%0d exp %b%b%b/%0d", n,
                         bus.wb_valid, bus.wb_regwrite, bus.wb_memtoreg, bus.wb_rd,
                         m_v[2], m_v[2] & m_c[2][3], m_c[2][4], m_r[2]);
            else pass_cnt++;
            total_cnt++;
            if ({bus.stall_count, bus.flush_count, bus_s.stall_count, bus_s.flush_count} !==
                {16'(m_sc), 16'(m_fc), 2'(m_sc2), 2'(m_fc2)})
                $display("FAIL rnd_cnt_%0d got %0d %0d %0d %0d exp %0d %0d %0d %0d", n,
                         bus.stall_count, bus.flush_count, bus_s.stall_count, bus_s.flush_count,
                         m_sc, m_fc, m_sc2, m_fc2);
            else pass_cnt++;
        end
        bus.hold = 1'b0;
        bus.flush = 1'b0;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset     = 1'b1;
        bus.hold  = 1'b0;
        bus.flush = 1'b0;
        drive(1'b0, 8'h00, 5'd0, 5'd0, 1'b0, 5'd0);
        test_reset();
        test_passthrough();
        test_load_use();
        test_no_false_hazard();
        test_flush_hazard();
        test_hold();
        test_async_reset();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
